// File: rtl/div_pkg.sv
// Shared types and limits for the divider blocks and their measurement monitor.
package div_pkg;
  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} meas_state_t;
  localparam int SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous clock-like input and flags its rising and falling edges.
// rise/fall are combinational from the last two synchronized samples.
module sync_edge
  import div_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  output logic rise,
  output logic fall
);
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [STAGES-1:0] sync_q, sync_d;
  logic              s_d_q, s_d_d;
  logic              s;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], clk_in};
    s_d_d  = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q  <= s_d_d;
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;
endmodule

// File: rtl/div_measure.sv
// Measures high time, low time and period of a divided clock in system-clock cycles,
// flags duty balance, declares lock on a stable period, and times out on a stuck level.
module div_measure
  import div_pkg::*;
#(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_in,
  output logic [W-1:0] high_cnt,
  output logic [W-1:0] low_cnt,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         balanced,
  output logic         locked,
  output logic         timeout
);
  localparam int            MW       = $clog2(LOCK_CNT + 1);
  localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0]  CNT_ONE  = W'(1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);

  logic rise, fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .clk_in (clk_in),
    .rise   (rise),
    .fall   (fall)
  );

  meas_state_t   state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  hi_r_q, hi_r_d;
  logic [W-1:0]  high_cnt_q, high_cnt_d;
  logic [W-1:0]  low_cnt_q, low_cnt_d;
  logic [W-1:0]  period_q, period_d;
  logic          valid_q, valid_d;
  logic          balanced_q, balanced_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;
  logic [MW-1:0] match_q, match_d;

  logic [W:0]    sum;
  logic [W-1:0]  period_sat;
  logic [W-1:0]  diff;
  logic [W-1:0]  cnt_inc;
  logic          stuck;

  always_comb begin
    sum        = {1'b0, hi_r_q} + {1'b0, cnt_q};
    period_sat = sum[W] ? CNT_MAX : sum[W-1:0];
    diff       = (hi_r_q >= cnt_q) ? (hi_r_q - cnt_q) : (cnt_q - hi_r_q);
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_r_d     = hi_r_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    balanced_d = balanced_q;
    locked_d   = locked_q;
    timeout_d  = 1'b0;
    match_d    = match_q;
    stuck      = 1'b0;

    unique case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          hi_r_d  = cnt_q;
          cnt_d   = CNT_ONE;
          state_d = MEAS_LOW;
        end else if (cnt_q == CNT_MAX) begin
          stuck = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          high_cnt_d = hi_r_q;
          low_cnt_d  = cnt_q;
          period_d   = period_sat;
          balanced_d = (diff <= CNT_ONE);
          valid_d    = 1'b1;
          // match_q == 0 means no prior period since reset/timeout to compare with
          if (match_q != '0 && period_sat == period_q)
            match_d = (match_q == MATCH_MAX) ? match_q : (match_q + MATCH_ONE);
          else
            match_d = MATCH_ONE;
          locked_d = (match_d == MATCH_MAX);
          cnt_d    = CNT_ONE;
          state_d  = MEAS_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          stuck = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = WAIT_RISE;
    endcase

    // Measured counts are left untouched so the last good result stays visible.
    if (stuck) begin
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      match_d   = '0;
      cnt_d     = '0;
      state_d   = WAIT_RISE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_RISE;
      cnt_q      <= '0;
      hi_r_q     <= '0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      balanced_q <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      match_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_r_q     <= hi_r_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      period_q   <= period_d;
      valid_q    <= valid_d;
      balanced_q <= balanced_d;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      match_q    <= match_d;
    end
  end

  assign high_cnt = high_cnt_q;
  assign low_cnt  = low_cnt_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign balanced = balanced_q;
  assign locked   = locked_q;
  assign timeout  = timeout_q;
endmodule

// File: tb/tb_div_measure.sv
// Bench for div_measure: scoreboarded measurements on a W=16 instance, timeout on a W=8 instance.
module tb_div_measure;
  localparam int LOCK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_in_m = 1'b0;
  logic        clk_in_t = 1'b0;

  logic [15:0] high_cnt_m, low_cnt_m, period_m;
  logic        valid_m, balanced_m, locked_m, timeout_m;
  logic [7:0]  high_cnt_t, low_cnt_t, period_t;
  logic        valid_t, balanced_t, locked_t, timeout_t;

  always #20 clk = ~clk;

  div_measure #(.W(16), .SYNC_STAGES(2), .LOCK_CNT(LOCK)) u_m (
    .clk(clk), .rst(rst), .clk_in(clk_in_m),
    .high_cnt(high_cnt_m), .low_cnt(low_cnt_m), .period(period_m),
    .valid(valid_m), .balanced(balanced_m), .locked(locked_m), .timeout(timeout_m)
  );

  div_measure #(.W(8), .SYNC_STAGES(2), .LOCK_CNT(LOCK)) u_t (
    .clk(clk), .rst(rst), .clk_in(clk_in_t),
    .high_cnt(high_cnt_t), .low_cnt(low_cnt_t), .period(period_t),
    .valid(valid_t), .balanced(balanced_t), .locked(locked_t), .timeout(timeout_t)
  );

  typedef struct {
    logic [15:0] h;
    logic [15:0] l;
    logic [15:0] p;
    logic        bal;
    logic        lck;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc = 0;
  int   n_valid_m = 0;
  int   last_valid_cyc = 0;
  int   last_gap = 0;

  // reference model state
  bit   have_prev = 0;
  int   prev_h = 0, prev_l = 0;
  int   model_match = 0;
  int   model_period = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every valid on the main instance must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_m) begin
      n_valid_m++;
      last_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got high=%0d low=%0d period=%0d, none expected",
                 high_cnt_m, low_cnt_m, period_m);
      end else begin
        e = exp_q.pop_front();
        if ({high_cnt_m, low_cnt_m, period_m, balanced_m, locked_m} !== {e.h, e.l, e.p, e.bal, e.lck}) begin
          errors++;
          $display("FAIL measurement: got h=%0d l=%0d p=%0d bal=%0b lck=%0b, want h=%0d l=%0d p=%0d bal=%0b lck=%0b",
                   high_cnt_m, low_cnt_m, period_m, balanced_m, locked_m, e.h, e.l, e.p, e.bal, e.lck);
        end
      end
    end
    if ((valid_m && timeout_m) || (valid_t && timeout_t)) begin
      vectors++;
      errors++;
      $display("FAIL valid_timeout_overlap: valid and timeout both high, want never together");
    end
  end

  task automatic push_expect(input int h, input int l);
    exp_t e;
    int   p;
    int   d;
    p = h + l;
    d = h - l;
    if (model_match != 0 && p == model_period)
      model_match = (model_match >= LOCK) ? LOCK : model_match + 1;
    else
      model_match = 1;
    model_period = p;
    e.h   = 16'(h);
    e.l   = 16'(l);
    e.p   = 16'(p);
    e.bal = (d <= 1 && d >= -1);
    e.lck = (model_match == LOCK);
    exp_q.push_back(e);
  endtask

  // One period, high first; the rise completes the previous period's measurement.
  task automatic drive_period(input int h, input int l);
    clk_in_m = 1'b1;
    if (have_prev) push_expect(prev_h, prev_l);
    prev_h = h;
    prev_l = l;
    have_prev = 1;
    repeat (h) @(negedge clk);
    clk_in_m = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic model_clear();
    have_prev = 0;
    model_match = 0;
    model_period = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clk_in_m = 1'b0;
    clk_in_t = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: %0d expected measurements never arrived, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({high_cnt_m, low_cnt_m, period_m} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counts_m: got %0d/%0d/%0d, want 0/0/0", high_cnt_m, low_cnt_m, period_m);
    end
    vectors++;
    if ({valid_m, balanced_m, locked_m, timeout_m} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags_m: got %b, want 0000", {valid_m, balanced_m, locked_m, timeout_m});
    end
    vectors++;
    if ({high_cnt_t, low_cnt_t, period_t, valid_t, balanced_t, locked_t, timeout_t} !== 28'd0) begin
      errors++;
      $display("FAIL reset_t: got nonzero outputs on W=8 instance, want all 0");
    end
    do_reset();
  endtask

  task automatic test_3h4l();
    int v0;
    do_reset();
    v0 = n_valid_m;
    for (int i = 0; i < 6; i++) drive_period(3, 4);
    vectors++;
    if (n_valid_m - v0 != 5) begin
      errors++;
      $display("FAIL 3h4l_count: got %0d valids, want 5", n_valid_m - v0);
    end
    vectors++;
    if (last_gap != 7) begin
      errors++;
      $display("FAIL 3h4l_spacing: got %0d cycles between valids, want 7", last_gap);
    end
    vectors++;
    if (locked_m !== 1'b1) begin
      errors++;
      $display("FAIL 3h4l_locked: got %b, want 1", locked_m);
    end
    check_drained("3h4l");
  endtask

  // divide-by-7 counter clocked by clk: high for 4 counts, low for 3
  task automatic test_div_odd();
    int k;
    bit lvl;
    int v0;
    do_reset();
    v0 = n_valid_m;
    k = 0;
    for (int c = 0; c < 7 * 6; c++) begin
      lvl = (k < 4);
      if (lvl && !clk_in_m) begin
        if (have_prev) push_expect(prev_h, prev_l);
        prev_h = 4;
        prev_l = 3;
        have_prev = 1;
      end
      clk_in_m = lvl;
      k = (k == 6) ? 0 : k + 1;
      @(negedge clk);
    end
    clk_in_m = 1'b0;
    vectors++;
    if (n_valid_m - v0 != 5 || locked_m !== 1'b1 || balanced_m !== 1'b1) begin
      errors++;
      $display("FAIL div_odd: got %0d valids locked=%b balanced=%b, want 5 valids locked=1 balanced=1",
               n_valid_m - v0, locked_m, balanced_m);
    end
    check_drained("div_odd");
  endtask

  task automatic test_unbalanced();
    do_reset();
    for (int i = 0; i < 6; i++) drive_period(2, 5);
    vectors++;
    if ({balanced_m, locked_m, period_m} !== {1'b0, 1'b1, 16'd7}) begin
      errors++;
      $display("FAIL unbalanced: got bal=%b lck=%b p=%0d, want bal=0 lck=1 p=7", balanced_m, locked_m, period_m);
    end
    check_drained("unbalanced");
  endtask

  task automatic test_lock_change();
    do_reset();
    for (int i = 0; i < 5; i++) drive_period(3, 4);
    drive_period(4, 5);
    vectors++;
    if (locked_m !== 1'b1 || period_m !== 16'd7) begin
      errors++;
      $display("FAIL lock_before_change: got lck=%b p=%0d, want lck=1 p=7", locked_m, period_m);
    end
    drive_period(4, 5);
    vectors++;
    if (locked_m !== 1'b0 || period_m !== 16'd9) begin
      errors++;
      $display("FAIL lock_drop: got lck=%b p=%0d, want lck=0 p=9", locked_m, period_m);
    end
    for (int i = 0; i < 4; i++) drive_period(4, 5);
    vectors++;
    if (locked_m !== 1'b1) begin
      errors++;
      $display("FAIL lock_regain: got %b, want 1", locked_m);
    end
    check_drained("lock_change");
  endtask

  task automatic test_timeout();
    int  k;
    bit  seen;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clk_in_t = 1'b1;
      repeat (3) @(negedge clk);
      clk_in_t = 1'b0;
      repeat (4) @(negedge clk);
    end
    clk_in_t = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      if (timeout_t) seen = 1;
      if (k == 5) begin
        vectors++;
        if (locked_t !== 1'b1) begin
          errors++;
          $display("FAIL timeout_prelock: got locked=%b, want 1", locked_t);
        end
      end
    end
    vectors++;
    if (!seen || k != 258) begin
      errors++;
      $display("FAIL timeout_latency: got pulse=%b after %0d cycles, want pulse after 258", seen, k);
    end
    vectors++;
    if ({locked_t, high_cnt_t, low_cnt_t, period_t} !== {1'b0, 8'd3, 8'd4, 8'd7}) begin
      errors++;
      $display("FAIL timeout_state: got lck=%b h=%0d l=%0d p=%0d, want lck=0 h=3 l=4 p=7",
               locked_t, high_cnt_t, low_cnt_t, period_t);
    end
    k = 0;
    repeat (300) begin
      @(negedge clk);
      if (timeout_t) k++;
    end
    vectors++;
    if (k != 0) begin
      errors++;
      $display("FAIL timeout_single: got %0d further pulses, want 0", k);
    end
    clk_in_t = 1'b0;
    repeat (4) @(negedge clk);
    clk_in_t = 1'b1;
    repeat (5) @(negedge clk);
    clk_in_t = 1'b0;
    repeat (2) @(negedge clk);
    clk_in_t = 1'b1;
    k = 0;
    seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (valid_t) seen = 1;
    end
    vectors++;
    if (!seen || {high_cnt_t, low_cnt_t, period_t, balanced_t, locked_t} !== {8'd5, 8'd2, 8'd7, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_resume: got valid=%b h=%0d l=%0d p=%0d bal=%b lck=%b, want valid h=5 l=2 p=7 bal=0 lck=0",
               seen, high_cnt_t, low_cnt_t, period_t, balanced_t, locked_t);
    end
    clk_in_t = 1'b0;
  endtask

  task automatic test_reset_mid();
    int v0;
    do_reset();
    drive_period(3, 4);
    drive_period(3, 4);
    drive_period(3, 2);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({high_cnt_m, low_cnt_m, period_m, valid_m, balanced_m, locked_m, timeout_m} !== 52'd0) begin
      errors++;
      $display("FAIL reset_mid_clear: got h=%0d l=%0d p=%0d flags=%b, want all 0",
               high_cnt_m, low_cnt_m, period_m, {valid_m, balanced_m, locked_m, timeout_m});
    end
    check_drained("reset_mid_pre");
    model_clear();
    clk_in_m = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    v0 = n_valid_m;
    drive_period(3, 4);
    vectors++;
    if (n_valid_m != v0) begin
      errors++;
      $display("FAIL reset_mid_early_valid: got %0d valids in first period, want 0", n_valid_m - v0);
    end
    drive_period(3, 4);
    vectors++;
    if (n_valid_m - v0 != 1 || locked_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_resume: got %0d valids lck=%b, want 1 valid lck=0", n_valid_m - v0, locked_m);
    end
    check_drained("reset_mid");
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_3h4l();
    test_div_odd();
    test_unbalanced();
    test_lock_change();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/div_measure.md
# div_measure

Measures the clock produced by the odd/even dividers, such as `div_odd`, against the system clock that drives them. It extracts high time, low time and period in system-clock cycles, flags whether the duty cycle is balanced, and declares lock once the period is stable. It is the checking end of the divider path: it is used in benches and on-chip as a divider health monitor.

## Interface
Parameters:
- `W`, default 16: width of all cycle counters.
- `SYNC_STAGES`, default 2: synchronizer depth on `clk_in`, minimum 2.
- `LOCK_CNT`, default 4: number of consecutive identical periods required for lock.

Ports:
- `clk` input, 1 bit: system clock. All logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `clk_in` input, 1 bit: divided clock under measurement. It is treated as asynchronous.
- `high_cnt` output, W bits: sampled-high cycles of the last complete period.
- `low_cnt` output, W bits: sampled-low cycles of the last complete period.
- `period` output, W bits: `high_cnt + low_cnt`, saturating at 2^W-1.
- `valid` output, 1 bit: one-cycle pulse when a new measurement is presented.
- `balanced` output, 1 bit: |high_cnt − low_cnt| ≤ 1 for the presented measurement.
- `locked` output, 1 bit: the last LOCK_CNT periods were equal.
- `timeout` output, 1 bit: one-cycle pulse when a level persists for 2^W-1 cycles.

## Operation
- `clk_in` passes through SYNC_STAGES flops to give `s`. A further flop gives `s_d`.
  - Rising edge: `rise = s & ~s_d`.
  - Falling edge: `fall = ~s & s_d`.
- State machine states: WAIT_RISE, MEAS_HIGH, MEAS_LOW. Reset state is WAIT_RISE.
  - WAIT_RISE: on `rise`, set `cnt` to 1 and go to MEAS_HIGH. A `fall` in this state is ignored.
  - MEAS_HIGH: `cnt` increments each cycle. On `fall`, latch `cnt` into `hi_r`, set `cnt` to 1 and go to MEAS_LOW.
  - MEAS_LOW: `cnt` increments each cycle. On `rise`:
    - register `high_cnt = hi_r`, `low_cnt = cnt` and `period = hi_r + cnt` (saturated);
    - compute `balanced`;
    - pulse `valid`;
    - set `cnt` to 1 and stay measuring by going to MEAS_HIGH.
- The first period after reset or after a timeout is always measured completely. No partial high phase is ever reported.
- Timeout: in MEAS_HIGH or MEAS_LOW, if `cnt` reaches 2^W-1 with no edge:
  - pulse `timeout`;
  - clear `locked` and the lock counter;
  - go to WAIT_RISE.
  - `high_cnt`, `low_cnt` and `period` hold their last values.
- Lock tracking: `match_cnt` saturates at LOCK_CNT.
  - On each `valid`, if the new `period` equals the previous `period`, increment `match_cnt`; otherwise set it to 1.
  - `locked = (match_cnt == LOCK_CNT)`, registered.
  - The first valid after reset or timeout sets `match_cnt` to 1.
- Arithmetic: `cnt` saturates and never wraps. The period sum is computed at W+1 bits and clamped to 2^W-1.

## Timing
- Reset values: all outputs are 0, state is WAIT_RISE, and the synchronizer, `cnt`, `hi_r` and `match_cnt` are 0.
- Latency: a rising edge of `clk_in` is seen as `rise` SYNC_STAGES+1 clk edges later. `valid`, the counts and `balanced` update on the clk edge after the `rise` cycle.
- `locked` updates in the same cycle as `valid`, evaluated with the new period.
- `valid` and `timeout` are never high in the same cycle.
- `balanced`, `high_cnt`, `low_cnt` and `period` are stable between `valid` pulses.
- `rise` and `fall` cannot occur in the same cycle, because `s` is single-bit.
- Asserting `rst` mid-period clears everything asynchronously. After release, measurement restarts from WAIT_RISE.
- The minimum measurable phase is 1 cycle. A pulse shorter than one clk period may be missed; this is accepted and not an error.

## Structure
- Shared package `div_pkg`:
  - state enum `meas_state_t` (WAIT_RISE, MEAS_HIGH, MEAS_LOW);
  - `SYNC_STAGES_MIN = 2`.
- Sub-module `sync_edge` (parameter SYNC_STAGES): synchronizer plus `rise`/`fall` detection, reusable by other divider blocks.
- Target size is about 150–250 lines of RTL.

## Test plan
- `clk_in` is an ideal pattern of 3 cycles high and 4 low, repeated, with defaults. Required: after the first full period, `valid` fires every 7 cycles with `high_cnt = 3`, `low_cnt = 4`, `period = 7` and `balanced = 1`. `locked` rises at the 4th `valid`.
- `clk_in` is driven from `div_odd` with N=7, clocked by `clk` (40 ns period). Required: `period = 7` on every `valid`, `balanced = 1`, and `locked = 1` after 4 periods.
- `clk_in` pattern is 2 high / 5 low. Required: `period = 7`, `balanced = 0`, and `locked` still asserts.
- Lock then change: lock on a period of 7, then switch to 4 high / 5 low. Required: the first valid with `period = 9` drops `locked`, and `locked` returns after 4 periods of 9.
- Timeout with W=8: hold `clk_in` at 1 after one `rise`. Required: a single `timeout` pulse 255 cycles after MEAS_HIGH entry, `locked = 0`, and earlier counts retained. A new edge resumes measurement.
- Reset mid-period: assert `rst` during MEAS_LOW. Required: all outputs are 0 immediately. After release, no `valid` appears until a full high+low period has elapsed.
